// File: rtl/aftab_rr_arbmux.sv
// Round-robin arbiter feeding a one-beat registered output stage.
// Grants one of numIn valid/ready channels per cycle; lock freezes the priority pointer.
module aftab_rr_arbmux #(
  parameter int size  = 32,
  parameter int numIn = 4,
  parameter int selW  = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [numIn-1:0]        inValid,
  input  logic [numIn*size-1:0]   inData,
  output logic [numIn-1:0]        inReady,
  input  logic                    lock,
  output logic                    outValid,
  output logic [size-1:0]         outData,
  output logic [selW-1:0]         outSel,
  input  logic                    outReady
);

  logic            out_valid_q, out_valid_d;
  logic [size-1:0] out_data_q,  out_data_d;
  logic [selW-1:0] out_sel_q,   out_sel_d;
  logic [selW-1:0] rr_ptr_q,    rr_ptr_d;

  logic            load_en;
  logic            grant_vld;
  logic [selW-1:0] grant_idx;
  logic [size-1:0] grant_data;
  logic            hi_vld, lo_vld;
  logic [selW-1:0] hi_idx, lo_idx;

  assign load_en = !out_valid_q || outReady;

  // Two-pass search: lowest valid index at or above the pointer wins,
  // otherwise the lowest valid index overall (the wrapped part of the ring).
  always_comb begin : grant_search
    // NOTE: every variable gets a default before any conditional write so no latch is inferred.
    hi_vld = 1'b0;
    hi_idx = '0;
    lo_vld = 1'b0;
    lo_idx = '0;
    for (int k = numIn - 1; k >= 0; k--) begin
      if (inValid[k]) begin
        lo_vld = 1'b1;
        lo_idx = selW'(k);
        if (selW'(k) >= rr_ptr_q) begin
          hi_vld = 1'b1;
          hi_idx = selW'(k);
        end
      end
    end
    grant_vld = lo_vld;
    grant_idx = hi_vld ? hi_idx : lo_idx;
  end

  // inReady is held low during reset even though the stage looks empty then.
  always_comb begin : grant_mux
    grant_data = '0;
    inReady    = '0;
    for (int k = 0; k < numIn; k++) begin
      if (grant_idx == selW'(k)) begin
        grant_data = inData[k*size +: size];
        inReady[k] = grant_vld && load_en && !rst;
      end
    end
  end

  always_comb begin : next_state
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_sel_d   = out_sel_q;
    rr_ptr_d    = rr_ptr_q;
    if (load_en) begin
      if (grant_vld) begin
        out_valid_d = 1'b1;
        out_data_d  = grant_data;
        out_sel_d   = grant_idx;
        if (!lock) begin
          rr_ptr_d = (grant_idx == selW'(numIn - 1)) ? '0 : grant_idx + selW'(1);
        end
      end else begin
        out_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sel_q   <= '0;
      rr_ptr_q    <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_sel_q   <= out_sel_d;
      rr_ptr_q    <= rr_ptr_d;
    end
  end

  assign outValid = out_valid_q;
  assign outData  = out_data_q;
  assign outSel   = out_sel_q;

endmodule

// File: tb/tb_aftab_rr_arbmux.sv
// Self-checking bench for aftab_rr_arbmux: directed scenarios plus random traffic
// compared against a queue-free behavioural model of the round-robin rules.
module tb_aftab_rr_arbmux;

  localparam int N = 4;
  localparam int W = 32;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   in_valid;
  logic [N*W-1:0] in_data;
  logic [N-1:0]   in_ready;
  logic           lock;
  logic           out_valid;
  logic [W-1:0]   out_data;
  logic [1:0]     out_sel;
  logic           out_ready;

  // Second instance with a non-power-of-two channel count.
  logic [2:0]     v3;
  logic [3*W-1:0] d3;
  logic [2:0]     rdy3;
  logic           valid3;
  logic [W-1:0]   data3;
  logic [1:0]     sel3;
  logic           ready3;

  int n_pass  = 0;
  int n_total = 0;

  // Reference state: held beat and round-robin pointer.
  int           m_ptr;
  bit           m_valid;
  logic [W-1:0] m_data;
  int           m_sel;

  always #5 clk = ~clk;

  aftab_rr_arbmux #(.size(W), .numIn(N), .selW(2)) dut (
    .clk(clk), .rst(rst), .inValid(in_valid), .inData(in_data), .inReady(in_ready),
    .lock(lock), .outValid(out_valid), .outData(out_data), .outSel(out_sel),
    .outReady(out_ready)
  );

  aftab_rr_arbmux #(.size(W), .numIn(3), .selW(2)) dut3 (
    .clk(clk), .rst(rst), .inValid(v3), .inData(d3), .inReady(rdy3),
    .lock(1'b0), .outValid(valid3), .outData(data3), .outSel(sel3),
    .outReady(ready3)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  function automatic int ref_grant();
    for (int i = 0; i < N; i++) begin
      int k = (m_ptr + i) % N;
      if (((in_valid >> k) & 1) != 0) return k;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_ptr   = 0;
    m_valid = 0;
    m_data  = '0;
    m_sel   = 0;
  endtask

  // One clock: check combinational ready, advance the model, check the registered stage.
  task automatic step(input string tag);
    int g;
    bit load;
    logic [N-1:0] exp_rdy;
    #1;
    load    = !m_valid || out_ready;
    g       = ref_grant();
    exp_rdy = '0;
    if (g >= 0 && load) exp_rdy = N'(1) << g;
    check({tag, "_rdy"}, 64'(in_ready), 64'(exp_rdy));
    @(posedge clk);
    if (load) begin
      if (g >= 0) begin
        m_valid = 1;
        m_data  = W'(in_data >> (g * W));
        m_sel   = g;
        if (!lock) m_ptr = (g + 1) % N;
      end else begin
        m_valid = 0;
      end
    end
    #1;
    check({tag, "_valid"}, 64'(out_valid), 64'(m_valid));
    check({tag, "_data"},  64'(out_data),  64'(m_data));
    check({tag, "_sel"},   64'(out_sel),   64'(m_sel));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst       = 1'b1;
    in_valid  = '1;
    in_data   = {4{32'h5555_AAAA}};
    lock      = 1'b0;
    out_ready = 1'b1;
    v3        = 3'b111;
    d3        = {32'hC2, 32'hC1, 32'hC0};
    ready3    = 1'b1;
    model_reset();

    // Reset held across edges with every channel requesting.
    #22;
    check("rst_valid", 64'(out_valid), 64'd0);
    check("rst_data",  64'(out_data),  64'd0);
    check("rst_sel",   64'(out_sel),   64'd0);
    check("rst_rdy",   64'(in_ready),  64'd0);
    check("rst_rdy3",  64'(rdy3),      64'd0);
    check("rst_valid3", 64'(valid3),   64'd0);
    v3 = 3'b000;
    @(negedge clk);
    rst = 1'b0;

    // Full rotation, one beat per cycle.
    in_valid = 4'hF;
    in_data  = {32'hA3, 32'hA2, 32'hA1, 32'hA0};
    for (int i = 0; i < 5; i++) begin
      step("rot");
      check("rot_sel_const",  64'(out_sel),  64'(i % 4));
      check("rot_data_const", 64'(out_data), 64'(32'hA0 + i % 4));
    end

    // Back-pressure on a single channel; the held beat must not follow inData.
    in_valid = 4'b0100;
    in_data  = {32'h0, 32'h1234, 32'h0, 32'h0};
    step("bp_load");
    check("bp_load_data", 64'(out_data), 64'h1234);
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_data[2*W +: W] = 32'h9000 + i;
      step("bp_hold");
      check("bp_hold_data", 64'(out_data), 64'h1234);
    end
    out_ready = 1'b1;
    in_data[2*W +: W] = 32'h5678;
    step("bp_release");
    check("bp_release_data", 64'(out_data), 64'h5678);

    // Pointer now at numIn-1: wrap to channel 0, pointer becomes 1.
    in_valid = 4'b0001;
    in_data  = {32'hD3, 32'hD2, 32'hD1, 32'hD0};
    step("wrap");
    check("wrap_sel", 64'(out_sel), 64'd0);
    in_valid = 4'b1011;
    step("wrap_next");
    check("wrap_next_sel", 64'(out_sel), 64'd1);

    // Bring pointer to 1, then lock with channels 1 and 3 requesting.
    in_valid = 4'b0001;
    step("lock_prep");
    lock     = 1'b1;
    in_valid = 4'b1010;
    for (int i = 0; i < 4; i++) begin
      step("lock");
      check("lock_sel", 64'(out_sel), 64'd1);
    end
    lock = 1'b0;
    step("unlock1");
    step("unlock2");
    check("unlock2_sel", 64'(out_sel), 64'd3);

    // Asynchronous reset with a beat held.
    in_valid = 4'b0001;
    in_data  = {32'h0, 32'h0, 32'h0, 32'hDEADBEEF};
    step("db_load");
    check("db_load_data", 64'(out_data), 64'hDEADBEEF);
    out_ready = 1'b0;
    in_valid  = '0;
    #3;
    rst = 1'b1;
    #1;
    in_valid = '1;
    #1;
    check("arst_valid", 64'(out_valid), 64'd0);
    check("arst_data",  64'(out_data),  64'd0);
    check("arst_sel",   64'(out_sel),   64'd0);
    check("arst_rdy",   64'(in_ready),  64'd0);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    out_ready = 1'b1;
    in_valid  = 4'b1000;
    in_data   = {32'hE3, 32'hE2, 32'hE1, 32'hE0};
    step("post_rst");
    check("post_rst_sel", 64'(out_sel), 64'd3);
    in_valid = 4'hF;
    step("post_rst_ptr");
    check("post_rst_ptr_sel", 64'(out_sel), 64'd0);

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      in_valid = N'($urandom());
      for (int k = 0; k < N; k++) in_data[k*W +: W] = $urandom();
      out_ready = ($urandom_range(0, 3) != 0);
      lock      = ($urandom_range(0, 7) == 0);
      step("rand");
    end
    lock     = 1'b0;
    in_valid = '0;

    // numIn = 3: seven transfers must cycle 0,1,2 and never show index 3.
    #1;
    v3 = 3'b111;
    #1;
    check("n3_rdy", 64'(rdy3), 64'b001);
    for (int i = 0; i < 7; i++) begin
      @(posedge clk);
      #1;
      check("n3_valid", 64'(valid3), 64'd1);
      check("n3_sel",   64'(sel3),   64'(i % 3));
      check("n3_data",  64'(data3),  64'(32'hC0 + i % 3));
      check("n3_sel_not3", 64'(sel3 == 2'd3), 64'd0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
